// File: rtl/alu_decode_queue.sv
// alu_decode_queue: instruction queue that decodes MIPS words at enqueue time.
// Each entry holds the instruction, its PC and pre-decoded ALU/branch/trap
// fields, so the head outputs come straight from storage with no decode logic.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous discard of all entries (highest priority)
//   in_valid/in_ready  upstream handshake; in_instr, in_pc are the payload
//   out_valid/out_ready downstream handshake on the head entry
//   out_instr, out_pc  head instruction word and PC
//   out_alu_control    ALU operation code (ALU_* codes below)
//   out_branch_control branch-judge code (ALU_EQ/NEQ/GTZ/LEZ/LTZ/GEZ/DONOTHING)
//   out_ov_chk         head needs an overflow trap check (ADD, SUB, ADDI)
//   out_muldiv         head is MULT/MULTU/DIV/DIVU
//   out_ri             head is a reserved instruction (0 when RI_EN=0)
//   count              number of occupied entries
module alu_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter bit          RI_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [4:0]                 out_alu_control,
  output logic [4:0]                 out_branch_control,
  output logic                       out_ov_chk,
  output logic                       out_muldiv,
  output logic                       out_ri,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // ALU / branch operation codes
  localparam logic [4:0] ALU_DONOTHING     = 5'd0;
  localparam logic [4:0] ALU_AND           = 5'd1;
  localparam logic [4:0] ALU_OR            = 5'd2;
  localparam logic [4:0] ALU_XOR           = 5'd3;
  localparam logic [4:0] ALU_NOR           = 5'd4;
  localparam logic [4:0] ALU_ADD           = 5'd5;
  localparam logic [4:0] ALU_SUB           = 5'd6;
  localparam logic [4:0] ALU_ADDU          = 5'd7;
  localparam logic [4:0] ALU_SUBU          = 5'd8;
  localparam logic [4:0] ALU_SLT           = 5'd9;
  localparam logic [4:0] ALU_SLTU          = 5'd10;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'd11;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd12;
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'd13;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd14;
  localparam logic [4:0] ALU_MTHI          = 5'd15;
  localparam logic [4:0] ALU_MTLO          = 5'd16;
  localparam logic [4:0] ALU_SLL_SA        = 5'd17;
  localparam logic [4:0] ALU_SRL_SA        = 5'd18;
  localparam logic [4:0] ALU_SRA_SA        = 5'd19;
  localparam logic [4:0] ALU_SLL           = 5'd20;
  localparam logic [4:0] ALU_SRL           = 5'd21;
  localparam logic [4:0] ALU_SRA           = 5'd22;
  localparam logic [4:0] ALU_LUI           = 5'd23;
  localparam logic [4:0] ALU_EQ            = 5'd24;
  localparam logic [4:0] ALU_NEQ           = 5'd25;
  localparam logic [4:0] ALU_GTZ           = 5'd26;
  localparam logic [4:0] ALU_LEZ           = 5'd27;
  localparam logic [4:0] ALU_LTZ           = 5'd28;
  localparam logic [4:0] ALU_GEZ           = 5'd29;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [4:0]  br;
    logic        ov;
    logic        md;
    logic        ri;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic            known_other;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign funct = in_instr[5:0];

  // Decoder on the enqueue side
  always_comb begin
    dec         = '0;
    dec.instr   = in_instr;
    dec.pc      = in_pc;
    dec.alu     = ALU_DONOTHING;
    dec.br      = ALU_DONOTHING;
    known_other = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h00: dec.alu = ALU_SLL_SA;
          6'h02: dec.alu = ALU_SRL_SA;
          6'h03: dec.alu = ALU_SRA_SA;
          6'h04: dec.alu = ALU_SLL;
          6'h06: dec.alu = ALU_SRL;
          6'h07: dec.alu = ALU_SRA;
          6'h11: dec.alu = ALU_MTHI;
          6'h13: dec.alu = ALU_MTLO;
          6'h18: begin dec.alu = ALU_SIGNED_MULT;   dec.md = 1'b1; end
          6'h19: begin dec.alu = ALU_UNSIGNED_MULT; dec.md = 1'b1; end
          6'h1A: begin dec.alu = ALU_SIGNED_DIV;    dec.md = 1'b1; end
          6'h1B: begin dec.alu = ALU_UNSIGNED_DIV;  dec.md = 1'b1; end
          6'h20: begin dec.alu = ALU_ADD; dec.ov = 1'b1; end
          6'h21: dec.alu = ALU_ADDU;
          6'h22: begin dec.alu = ALU_SUB; dec.ov = 1'b1; end
          6'h23: dec.alu = ALU_SUBU;
          6'h24: dec.alu = ALU_AND;
          6'h25: dec.alu = ALU_OR;
          6'h26: dec.alu = ALU_XOR;
          6'h27: dec.alu = ALU_NOR;
          6'h2A: dec.alu = ALU_SLT;
          6'h2B: dec.alu = ALU_SLTU;
          // JR, JALR, SYSCALL, BREAK, MFHI, MFLO: legal but no ALU/branch op
          6'h08, 6'h09, 6'h0C, 6'h0D, 6'h10, 6'h12: known_other = 1'b1;
          default: ;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h10: dec.br = ALU_LTZ;
          5'h01, 5'h11: dec.br = ALU_GEZ;
          default: ;
        endcase
      end
      6'h02, 6'h03: known_other = 1'b1;
      6'h04: dec.br = ALU_EQ;
      6'h05: dec.br = ALU_NEQ;
      6'h06: dec.br = ALU_LEZ;
      6'h07: dec.br = ALU_GTZ;
      6'h08: begin dec.alu = ALU_ADD; dec.ov = 1'b1; end
      6'h09: dec.alu = ALU_ADDU;
      6'h0A: dec.alu = ALU_SLT;
      6'h0B: dec.alu = ALU_SLTU;
      6'h0C: dec.alu = ALU_AND;
      6'h0D: dec.alu = ALU_OR;
      6'h0E: dec.alu = ALU_XOR;
      6'h0F: dec.alu = ALU_LUI;
      // COP0: MFC0 (rs=0), MTC0 (rs=4), ERET (CO=1, funct=0x18)
      6'h10: begin
        if (rs == 5'h00 || rs == 5'h04) begin
          known_other = 1'b1;
        end else if (rs == 5'h10 && funct == 6'h18) begin
          known_other = 1'b1;
        end
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: dec.alu = ALU_ADDU;
      default: ;
    endcase
    dec.ri = RI_EN && (dec.alu == ALU_DONOTHING) && (dec.br == ALU_DONOTHING) && !known_other;
  end

  assign not_empty = (cnt != '0);
  assign in_ready  = (cnt < CW'(DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign pop       = not_empty && out_ready && !flush;

  // Occupancy and pointers; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; contents are only visible while counted as occupied
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head = mem[rd_ptr];

  // Head outputs, forced to the empty values when nothing is queued
  always_comb begin
    out_valid          = not_empty;
    out_instr          = '0;
    out_pc             = '0;
    out_alu_control    = ALU_DONOTHING;
    out_branch_control = ALU_DONOTHING;
    out_ov_chk         = 1'b0;
    out_muldiv         = 1'b0;
    out_ri             = 1'b0;
    if (not_empty) begin
      out_instr          = head.instr;
      out_pc             = head.pc;
      out_alu_control    = head.alu;
      out_branch_control = head.br;
      out_ov_chk         = head.ov;
      out_muldiv         = head.md;
      out_ri             = head.ri;
    end
  end

  assign count = cnt;

endmodule

// File: tb/tb_alu_decode_queue.sv
// Directed bench for alu_decode_queue: one RI_EN=1 instance and one RI_EN=0
// instance share all inputs.
module tb_alu_decode_queue;

  localparam logic [4:0] DN    = 5'd0;
  localparam logic [4:0] ADD   = 5'd5;
  localparam logic [4:0] ADDU  = 5'd7;
  localparam logic [4:0] SDIV  = 5'd11;
  localparam logic [4:0] EQ    = 5'd24;
  localparam logic [4:0] GEZ   = 5'd29;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ov, a_md, a_ri;
  logic [31:0] a_instr, a_pc;
  logic [4:0]  a_alu, a_br;
  logic [2:0]  a_count;

  logic        b_in_ready, b_out_valid, b_ov, b_md, b_ri;
  logic [31:0] b_instr, b_pc;
  logic [4:0]  b_alu, b_br;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pc_next;
  logic        acc;

  alu_decode_queue #(.DEPTH(4), .RI_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc),
    .out_alu_control(a_alu), .out_branch_control(a_br),
    .out_ov_chk(a_ov), .out_muldiv(a_md), .out_ri(a_ri), .count(a_count)
  );

  alu_decode_queue #(.DEPTH(4), .RI_EN(1'b0)) dut_nori (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc),
    .out_alu_control(b_alu), .out_branch_control(b_br),
    .out_ov_chk(b_ov), .out_muldiv(b_md), .out_ri(b_ri), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", a_out_valid, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_count", a_count, 0);
    check("rst_alu",   a_alu, DN);
    check("rst_br",    a_br, DN);
    check("rst_pc",    a_pc, 0);
    check("rst_ri",    a_ri, 0);
    rst = 1'b0;

    // add $2,$4,$5: one-cycle latency, no bypass
    in_valid = 1'b1; in_instr = 32'h00851020; in_pc = 32'h1000;
    #1;
    check("add_nobypass", a_out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("add_valid", a_out_valid, 1);
    check("add_alu",   a_alu, ADD);
    check("add_br",    a_br, DN);
    check("add_ov",    a_ov, 1);
    check("add_ri",    a_ri, 0);
    check("add_pc",    a_pc, 32'h1000);
    check("add_instr", a_instr, 32'h00851020);
    check("add_count", a_count, 1);
    pop();
    check("add_drained", a_out_valid, 0);

    // beq, bgezal, div in order
    push(32'h10850003, 32'h2000);
    push(32'h04110002, 32'h2004);
    push(32'h0085001A, 32'h2008);
    check("seq_count", a_count, 3);
    check("beq_br",    a_br, EQ);
    check("beq_alu",   a_alu, DN);
    check("beq_ri",    a_ri, 0);
    pop();
    check("bgezal_br",  a_br, GEZ);
    check("bgezal_alu", a_alu, DN);
    check("bgezal_pc",  a_pc, 32'h2004);
    pop();
    check("div_alu", a_alu, SDIV);
    check("div_br",  a_br, DN);
    check("div_md",  a_md, 1);
    check("div_ov",  a_ov, 0);
    check("div_pc",  a_pc, 32'h2008);
    pop();
    check("seq_empty", a_out_valid, 0);

    // reserved instructions, with and without detection
    push(32'hFC000000, 32'h3000);
    push(32'h04050000, 32'h3004);
    check("ri_op3f",      a_ri, 1);
    check("ri_op3f_off",  b_ri, 0);
    check("ri_off_count", b_count, 2);
    pop();
    check("ri_regimm5",     a_ri, 1);
    check("ri_regimm5_off", b_ri, 0);
    check("ri_regimm5_pc",  a_pc, 32'h3004);
    pop();

    // fill to capacity, fifth push refused
    for (int i = 0; i < 4; i++) push(32'h00851021, 32'h100 + 32'(4 * i));
    check("full_count", a_count, 4);
    check("full_ready", a_in_ready, 0);
    push(32'h00851021, 32'h110);
    check("full_5th_count", a_count, 4);
    check("full_head_pc",   a_pc, 32'h100);
    check("full_alu",       a_alu, ADDU);

    // drain with continuous push; in_ready only reflects registered occupancy
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    pc_next = 32'h200;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00851021;
    for (int k = 0; k < 8; k++) begin
      in_pc = pc_next;
      acc = (exp_q.size() < 4);
      #1;
      check("wrap_pc",    a_pc, exp_q[0]);
      check("wrap_count", a_count, 32'(exp_q.size()));
      check("wrap_ready", a_in_ready, 32'(acc));
      @(posedge clk); #1;
      void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(pc_next);
        pc_next = pc_next + 32'd4;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_end_count", a_count, 3);
    check("wrap_end_pc",    a_pc, 32'h210);

    // flush beats concurrent push and pop
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h5000; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", a_count, 0);
    check("flush_valid", a_out_valid, 0);
    check("flush_alu",   a_alu, DN);
    check("flush_ready", a_in_ready, 1);
    push(32'h00851020, 32'h6000);
    check("postflush_pc",    a_pc, 32'h6000);
    check("postflush_count", a_count, 1);
    push(32'h00851021, 32'h6004);
    check("prerst_count", a_count, 2);

    // asynchronous reset between edges
    rst = 1'b1;
    #2;
    check("arst_valid", a_out_valid, 0);
    check("arst_count", a_count, 0);
    check("arst_ready", a_in_ready, 1);
    check("arst_alu",   a_alu, DN);
    check("arst_pc",    a_pc, 0);
    rst = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00851020; in_pc = 32'h7000;
    #1;
    check("postrst_nobypass", a_out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("postrst_valid", a_out_valid, 1);
    check("postrst_pc",    a_pc, 32'h7000);
    check("postrst_count", a_count, 1);
    check("postrst_alu",   a_alu, ADD);
    pop();
    check("postrst_empty", a_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
